// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the HI/LO register pair.
// mult/multu run for MULT_CYCLES and div/divu for DIV_CYCLES cycles with busy high.
// The result lands in HI/LO on the edge where the down-counter reaches zero.
// mthi/mtlo write HI/LO directly while the unit is idle.
// Build option: define MD_DIV_EN to include the divider datapath.
// Without it, div/divu decode as no-ops.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Low 64 bits of the product of the 64-bit sign/zero extended operands.
    // This equals the exact 64-bit product in both signed and unsigned modes.
    function automatic logic [63:0] mul_res(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ae;
        logic [63:0] be;
        ae = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        be = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ae * be;
    endfunction

`ifdef MD_DIV_EN
    // Divide on magnitudes, then fix the signs, giving {remainder, quotient}.
    // This avoids relying on the semantics of native signed division (e.g. INT_MIN / -1).
    // The quotient truncates toward zero and the remainder takes the dividend's sign.
    function automatic logic [63:0] div_res(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        ma    = neg_a ? (32'd0 - a) : a;
        mb    = neg_b ? (32'd0 - b) : b;
        q     = ma / mb;
        r     = ma % mb;
        q     = (neg_a ^ neg_b) ? (32'd0 - q) : q;
        r     = neg_a ? (32'd0 - r) : r;
        return {r, q};
    endfunction
`endif

    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [63:0]   res_s;
    logic          wr_s;

    // Result of the captured operation and whether completion may write HI/LO.
    always_comb begin
        res_s = 64'd0;
        wr_s  = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_s = mul_res(1'b1, a_q, b_q);
                wr_s  = 1'b1;
            end
            OP_MULTU: begin
                res_s = mul_res(1'b0, a_q, b_q);
                wr_s  = 1'b1;
            end
`ifdef MD_DIV_EN
            OP_DIV: begin
                res_s = div_res(1'b1, a_q, b_q);
                wr_s  = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_s = div_res(1'b0, a_q, b_q);
                wr_s  = (b_q != 32'd0);
            end
`endif
            default: begin
                res_s = 64'd0;
                wr_s  = 1'b0;
            end
        endcase
    end

    // Next-state logic: count down while busy, otherwise decode a new op.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (cnt_q != CNT_ZERO) begin
            // In flight: new ops are ignored; the hazard unit stalls the pipe.
            cnt_d = cnt_q - CNT_ONE;
            if ((cnt_q == CNT_ONE) && wr_s) begin
                hi_d = res_s[63:32];
                lo_d = res_s[31:0];
            end else begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end else begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    cnt_d = MULT_LOAD;
                    op_d  = md_op;
                    a_d   = rs;
                    b_d   = rt;
                end
`ifdef MD_DIV_EN
                OP_DIV, OP_DIVU: begin
                    cnt_d = DIV_LOAD;
                    op_d  = md_op;
                    a_d   = rs;
                    b_d   = rt;
                end
`endif
                OP_MTHI: hi_d = rs;
                OP_MTLO: lo_d = rs;
                OP_NONE: cnt_d = CNT_ZERO;
                default: cnt_d = CNT_ZERO;
            endcase
        end
        busy_d = (cnt_d != CNT_ZERO);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= CNT_ZERO;
            busy_q <= 1'b0;
            op_q   <= OP_NONE;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of cycles busy stays high for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of cycles busy stays high for div/divu.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port md_op  input  3  E-stage operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-006 SHALL have port rs  input  32  forwarded E-stage rs operand (rse_out).
REQ-007 SHALL have port rt  input  32  forwarded E-stage rt operand (rte_out).
REQ-008 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-009 SHALL have port hi  output  32  HI register contents.
REQ-010 SHALL have port lo  output  32  LO register contents.

Function
REQ-011 A start SHALL be accepted on a rising edge where md_op is in 1..4 and busy=0; rs/rt are captured on that edge.
REQ-012 On start, an internal down-counter SHALL load MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); busy = (counter != 0).
REQ-013 Each edge with counter != 0 SHALL decrement it; on the edge where it goes 1->0, hi/lo SHALL load the result, so new hi/lo are visible in the first cycle that busy=0.
REQ-014 mult: {hi,lo} = signed 64-bit product of rs and rt; multu: unsigned 64-bit product.
REQ-015 div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend; divu: unsigned quotient/remainder.
REQ-016 A divide with rt=0 SHALL run the full DIV_CYCLES with busy high and SHALL leave hi/lo unchanged.
REQ-017 mthi (5) / mtlo (6) with busy=0 SHALL write rs into hi / lo on that edge, with no busy cycle.
REQ-018 Any md_op other than none arriving while busy=1 SHALL be ignored (no restart, no operand recapture, no hi/lo write); the hazard unit is responsible for stalling.
REQ-019 md_op none SHALL change no state other than the counter decrement.
REQ-020 hi and lo SHALL only change on a completion edge, an accepted mthi/mtlo, or reset.

Reset
REQ-021 With reset=1 at an edge: counter=0, busy=0, hi=0, lo=0, captured operands=0, regardless of any in-flight operation or md_op.
REQ-022 An operation interrupted by reset SHALL never write hi/lo afterwards.
REQ-023 The edge after reset deasserts SHALL accept a new start normally.

Configuration
REQ-024 Macro MD_DIV_EN SHALL gate the divider datapath.
REQ-025 With MD_DIV_EN defined, div/divu SHALL behave per REQ-012..REQ-016.
REQ-026 Without MD_DIV_EN, md_op 3 and 4 SHALL be treated as none: busy is not raised and hi/lo are unchanged. mult/multu and mthi/mtlo are unaffected.

Verification
REQ-027 Scenario mult: rs=0xFFFFFFFE, rt=0x00000003. Required response: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-028 Scenario multu: rs=0xFFFFFFFE, rt=0x00000003. Required response: busy high 5 cycles, then hi=0x00000002, lo=0xFFFFFFFA.
REQ-029 Scenario div (MD_DIV_EN defined): rs=0xFFFFFFF9 (-7), rt=0x00000002. Required response: busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without MD_DIV_EN: busy stays 0 and hi/lo are unchanged.
REQ-030 Scenario divide by zero: preload hi=0x11111111, lo=0x22222222 via mthi/mtlo, then div rt=0. Required response: busy high 10 cycles, hi/lo still 0x11111111/0x22222222.
REQ-031 Scenario ops during busy: start mult 3*4, then in busy cycle 2 issue mtlo rs=0xDEADBEEF and div. Required response: both ignored; completion gives hi=0, lo=0x0000000C, and busy falls after the original 5 cycles.
REQ-032 Scenario reset mid-op: start multu 0xFFFFFFFF*0xFFFFFFFF, assert reset in busy cycle 3. Required response: next cycle busy=0, hi=0, lo=0, and they stay 0 through the cycles where completion would have occurred.
